// File: rtl/axi_addr_xlate_arb_if.sv
// axi_addr_xlate_arb_if: request, translation-engine and transmitter signals of the address-translation arbiter
interface axi_addr_xlate_arb_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  w_req_valid;
  logic                  r_req_valid;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic                  w_req_ready;
  logic                  r_req_ready;
  logic                  w_tx_busy;
  logic                  r_tx_busy;
  logic                  xl_start;
  logic [ADDR_WIDTH-1:0] xl_vaddr;
  logic                  xl_done;
  logic                  xl_miss;
  logic [ADDR_WIDTH-1:0] xl_paddr;
  logic [ADDR_WIDTH-1:0] phy_addr;
  logic                  w_t_done;
  logic                  r_t_done;
  logic                  err_valid;
  logic                  err_chan;
  logic                  err_code;
  logic                  busy;

  modport slave (
    input  w_req_valid, r_req_valid, w_req_addr, r_req_addr,
    input  w_tx_busy, r_tx_busy,
    input  xl_done, xl_miss, xl_paddr,
    output w_req_ready, r_req_ready,
    output xl_start, xl_vaddr,
    output phy_addr, w_t_done, r_t_done,
    output err_valid, err_chan, err_code, busy
  );

  modport master (
    output w_req_valid, r_req_valid, w_req_addr, r_req_addr,
    output w_tx_busy, r_tx_busy,
    output xl_done, xl_miss, xl_paddr,
    input  w_req_ready, r_req_ready,
    input  xl_start, xl_vaddr,
    input  phy_addr, w_t_done, r_t_done,
    input  err_valid, err_chan, err_code, busy
  );
endinterface

// File: rtl/axi_addr_xlate_arb.sv
// axi_addr_xlate_arb: round-robin arbiter sharing one address-translation engine between write and read channels
module axi_addr_xlate_arb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic tx_clk,
  input logic reset_,
  axi_addr_xlate_arb_if.slave bus
);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, DELIVER, ERROR} state_t;

  state_t                state, state_n;
  logic                  armed;
  logic                  ptr;
  logic                  chan;
  logic [15:0]           cnt;
  logic                  elig_w, elig_r, gnt_r;
  logic                  grant, done_ok, go_del, go_err, err_code_n;
  logic [ADDR_WIDTH-1:0] gnt_addr;

  // armed gates the first edge after reset release so the earliest grant is the second edge
  assign elig_w   = armed & bus.w_req_valid & ~bus.w_tx_busy;
  assign elig_r   = armed & bus.r_req_valid & ~bus.r_tx_busy;
  assign gnt_r    = elig_r & (~elig_w | ptr);
  assign gnt_addr = gnt_r ? bus.r_req_addr : bus.w_req_addr;
  // xl_done is ignored in the launch cycle, where xl_start is still high
  assign done_ok  = bus.xl_done & ~bus.xl_start;

  // next-state and transition decode; done beats timeout when both land in the same cycle
  always_comb begin
    state_n    = state;
    grant      = 1'b0;
    go_del     = 1'b0;
    go_err     = 1'b0;
    err_code_n = 1'b0;
    case (state)
      IDLE: begin
        grant   = elig_w | elig_r;
        state_n = grant ? LOOKUP : IDLE;
      end
      LOOKUP: begin
        go_del     = done_ok & ~bus.xl_miss;
        go_err     = done_ok ? bus.xl_miss : cnt == TMO_LAST;
        err_code_n = ~done_ok;
        state_n    = go_del ? DELIVER : go_err ? ERROR : LOOKUP;
      end
      default: state_n = IDLE;
    endcase
  end

  // state, lookup context and registered outputs
  always_ff @(posedge tx_clk or negedge reset_) begin
    if (!reset_) begin
      state           <= IDLE;
      armed           <= 1'b0;
      ptr             <= 1'b0;
      chan            <= 1'b0;
      cnt             <= '0;
      bus.xl_start    <= 1'b0;
      bus.xl_vaddr    <= '0;
      bus.phy_addr    <= '0;
      bus.w_t_done    <= 1'b0;
      bus.r_t_done    <= 1'b0;
      bus.w_req_ready <= 1'b0;
      bus.r_req_ready <= 1'b0;
      bus.err_valid   <= 1'b0;
      bus.err_chan    <= 1'b0;
      bus.err_code    <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      state           <= state_n;
      armed           <= 1'b1;
      bus.xl_start    <= grant;
      bus.w_t_done    <= go_del & ~chan;
      bus.r_t_done    <= go_del & chan;
      bus.w_req_ready <= (go_del | go_err) & ~chan;
      bus.r_req_ready <= (go_del | go_err) & chan;
      bus.err_valid   <= go_err;
      bus.err_chan    <= go_err & chan;
      bus.err_code    <= go_err & err_code_n;
      bus.busy        <= state_n != IDLE;
      if (grant) begin
        chan         <= gnt_r;
        bus.xl_vaddr <= gnt_addr;
        cnt          <= '0;
      end else if (state == LOOKUP) begin
        cnt <= cnt + 16'd1;
      end
      if (go_del) bus.phy_addr <= bus.xl_paddr;
      if (state == DELIVER || state == ERROR) ptr <= ~chan;
    end
  end
endmodule

// File: tb/tb_axi_addr_xlate_arb.sv
// tb_axi_addr_xlate_arb: directed vector table plus reset, backpressure and abort sequences
module tb_axi_addr_xlate_arb;
  logic tx_clk;
  logic reset_;
  int   n_chk;
  int   n_fail;
  logic [31:0] exp_phy;

  axi_addr_xlate_arb_if #(.ADDR_WIDTH(32)) bus();

  axi_addr_xlate_arb #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .tx_clk (tx_clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  typedef struct {
    logic        wv, rv, wb, rb;
    logic [31:0] wa, ra;
    int          dly;
    logic        miss;
    logic [31:0] pa;
    logic        chan, err, code;
  } vec_t;

  vec_t tbl[8];

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  function automatic logic [6:0] pulses();
    return {bus.w_t_done, bus.r_t_done, bus.w_req_ready, bus.r_req_ready,
            bus.err_valid, bus.err_chan, bus.err_code};
  endfunction

  task automatic run(input vec_t v, input int idx);
    bus.w_req_valid = v.wv;
    bus.r_req_valid = v.rv;
    bus.w_tx_busy   = v.wb;
    bus.r_tx_busy   = v.rb;
    bus.w_req_addr  = v.wa;
    bus.r_req_addr  = v.ra;
    for (int i = 0; i < 20 && !bus.xl_start; i++) tick();
    chk($sformatf("v%0d_grant", idx), bus.xl_start, 1);
    chk($sformatf("v%0d_vaddr", idx), bus.xl_vaddr, v.chan ? v.ra : v.wa);
    chk($sformatf("v%0d_busy", idx), bus.busy, 1);
    if (v.dly == 0) begin
      repeat (7) tick();
      chk($sformatf("v%0d_no_early_err", idx), bus.err_valid, 0);
      tick();
    end else begin
      repeat (v.dly) tick();
      bus.xl_done  = 1'b1;
      bus.xl_miss  = v.miss;
      bus.xl_paddr = v.pa;
      tick();
      bus.xl_done  = 1'b0;
      bus.xl_miss  = 1'b0;
    end
    if (!v.err) exp_phy = v.pa;
    chk($sformatf("v%0d_pulses", idx), pulses(),
        {!v.err && !v.chan, !v.err && v.chan, !v.chan, v.chan, v.err, v.err && v.chan, v.err && v.code});
    chk($sformatf("v%0d_phy", idx), bus.phy_addr, exp_phy);
    chk($sformatf("v%0d_busy_out", idx), bus.busy, 1);
    if (v.chan) bus.r_req_valid = 1'b0;
    else bus.w_req_valid = 1'b0;
    tick();
    chk($sformatf("v%0d_single_pulse", idx), pulses(), 0);
    chk($sformatf("v%0d_idle", idx), bus.busy, 0);
  endtask

  initial begin
    logic seen;
    n_chk   = 0;
    n_fail  = 0;
    exp_phy = 32'h0;
    //            wv    rv    wb    rb    wa            ra            dly miss  pa            chan  err   code
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_2000, 2, 1'b0, 32'h8000_1000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1100, 32'h0000_2000, 1, 1'b0, 32'h8000_2000, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1100, 32'h0000_2200, 3, 1'b0, 32'h9000_1100, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_2200, 2, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_3000, 0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3300, 32'h0000_4400, 2, 1'b0, 32'hA000_4400, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3300, 32'h0000_0000, 4, 1'b0, 32'hB000_3300, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_6600, 7, 1'b0, 32'hC0DE_0000, 1'b1, 1'b0, 1'b0};
    reset_          = 1'b1;
    bus.w_req_valid = 1'b0;
    bus.r_req_valid = 1'b0;
    bus.w_req_addr  = '0;
    bus.r_req_addr  = '0;
    bus.w_tx_busy   = 1'b0;
    bus.r_tx_busy   = 1'b0;
    bus.xl_done     = 1'b0;
    bus.xl_miss     = 1'b0;
    bus.xl_paddr    = '0;
    #2 reset_ = 1'b0;
    bus.w_req_valid = 1'b1;
    bus.r_req_valid = 1'b1;
    bus.w_req_addr  = 32'h0000_1000;
    bus.r_req_addr  = 32'h0000_2000;
    repeat (2) tick();
    chk("reset_ctrl", {bus.xl_start, pulses(), bus.busy}, 0);
    chk("reset_vaddr", bus.xl_vaddr, 0);
    chk("reset_phy", bus.phy_addr, 0);
    reset_ = 1'b1;
    tick();
    chk("no_grant_first_edge", {bus.xl_start, bus.busy}, 0);
    for (int i = 0; i < 8; i++) run(tbl[i], i);
    bus.w_req_valid = 1'b1;
    bus.w_req_addr  = 32'h0000_5000;
    bus.w_tx_busy   = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | bus.xl_start | bus.busy;
    end
    chk("tx_busy_blocks", seen, 0);
    run('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5000, 32'h0, 1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0}, 20);
    bus.w_req_valid = 1'b1;
    bus.w_req_addr  = 32'h0000_7100;
    for (int i = 0; i < 20 && !bus.xl_start; i++) tick();
    chk("abort_grant", bus.xl_start, 1);
    tick();
    reset_ = 1'b0;
    #1;
    exp_phy = 32'h0;
    chk("abort_ctrl", {bus.xl_start, pulses(), bus.busy}, 0);
    chk("abort_vaddr", bus.xl_vaddr, 0);
    chk("abort_phy", bus.phy_addr, 0);
    bus.w_req_valid = 1'b0;
    tick();
    reset_ = 1'b1;
    tick();
    bus.xl_done  = 1'b1;
    bus.xl_paddr = 32'hEEEE_EEEE;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.xl_done = 1'b0;
      seen = seen | (|pulses()) | bus.busy | bus.xl_start;
    end
    chk("late_done_ignored", seen, 0);
    chk("late_done_phy", bus.phy_addr, 0);
    run('{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_7000, 32'h0000_7700, 2, 1'b0, 32'hD000_7000, 1'b0, 1'b0, 1'b0}, 30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
